present_dec: RTL and testbench

PRESENT_DEC -- requirements
Module: present_dec

---
 rtl/present_dec.sv | 257 +++++++++++++++++++++++++
 tb/tb_present_dec.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/present_dec.sv
// present_dec: iterative PRESENT-80 block decryptor, one round per clock.
// Ports: clk, rst_n (async, active-low); start, ct[63:0], key[79:0] in;
//        busy, done (1-cycle pulse), pt[63:0] (registered) out.
// Build option PRESENT_KEYEXP_EN: key is the user key and a forward
// schedule (KEYEXP) derives K32 on chip; when undefined, key must
// already be K32 and whitening is applied at start acceptance.
module present_dec #(
   parameter int ROUNDS = 31
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [63:0] ct,
   input  logic [79:0] key,
   output logic        busy,
   output logic        done,
   output logic [63:0] pt
);

   localparam logic [4:0] LAST = 5'(ROUNDS);

`ifdef PRESENT_KEYEXP_EN
   typedef enum logic [1:0] {
      S_IDLE, S_KEYEXP, S_DECRYPT, S_DONE
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE, S_DECRYPT, S_DONE
   } state_t;
`endif

   state_t      r_fsm;
   state_t      w_fsm_nxt;
   logic [63:0] r_state;
   logic [79:0] r_key;
   logic [4:0]  r_rnd;
   logic [63:0] r_pt;

   logic [79:0] w_kr;
   logic [63:0] w_din;
   logic [63:0] w_rnd_out;

`ifdef PRESENT_KEYEXP_EN
   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] y;
      unique case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         default: y = 4'h2;
      endcase
      return y;
   endfunction

   function automatic logic [79:0] key_fwd(
      input logic [79:0] k,
      input logic [4:0]  rc
   );
      logic [79:0] t;
      t          = {k[18:0], k[79:19]};
      t[79:76]   = sbox(t[79:76]);
      t[19:15]   = t[19:15] ^ rc;
      return t;
   endfunction
`endif

   function automatic logic [3:0] invs(input logic [3:0] x);
      logic [3:0] y;
      unique case (x)
         4'h0: y = 4'h5;
         4'h1: y = 4'hE;
         4'h2: y = 4'hF;
         4'h3: y = 4'h8;
         4'h4: y = 4'hC;
         4'h5: y = 4'h1;
         4'h6: y = 4'h2;
         4'h7: y = 4'hD;
         4'h8: y = 4'hB;
         4'h9: y = 4'h4;
         4'hA: y = 4'h6;
         4'hB: y = 4'h3;
         4'hC: y = 4'h0;
         4'hD: y = 4'h7;
         4'hE: y = 4'h9;
         default: y = 4'hA;
      endcase
      return y;
   endfunction

   // Forward pLayer sends bit i to 16*i mod 63; this pulls it back.
   function automatic logic [63:0] inv_p(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 63; i++) begin
         y[i] = x[(16 * i) % 63];
      end
      y[63] = x[63];
      return y;
   endfunction

   function automatic logic [63:0] inv_sl(input logic [63:0] x);
      logic [63:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) begin
         y[4*i +: 4] = invs(x[4*i +: 4]);
      end
      return y;
   endfunction

   // Undo one forward key update: K(r+1) -> K(r).
   function automatic logic [79:0] key_inv(
      input logic [79:0] k,
      input logic [4:0]  rc
   );
      logic [79:0] t;
      t        = k;
      t[19:15] = t[19:15] ^ rc;
      t[79:76] = invs(t[79:76]);
      return {t[60:0], t[79:61]};
   endfunction

   assign w_kr = key_inv(r_key, r_rnd);

`ifdef PRESENT_KEYEXP_EN
   // First DECRYPT cycle is the one where r_key first holds K32;
   // whitening is folded into that round's input.
   assign w_din = (r_fsm == S_DECRYPT && r_rnd == LAST)
                ? (r_state ^ r_key[79:16]) : r_state;
`else
   assign w_din = r_state;
`endif

   assign w_rnd_out = inv_sl(inv_p(w_din)) ^ w_kr[79:16];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fsm <= S_IDLE;
      end else begin
         r_fsm <= w_fsm_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_fsm_nxt = r_fsm;
      unique case (r_fsm)
         S_IDLE: begin
            if (start) begin
`ifdef PRESENT_KEYEXP_EN
               w_fsm_nxt = S_KEYEXP;
`else
               w_fsm_nxt = S_DECRYPT;
`endif
            end
         end
`ifdef PRESENT_KEYEXP_EN
         S_KEYEXP: begin
            if (r_rnd == LAST) begin
               w_fsm_nxt = S_DECRYPT;
            end
         end
`endif
         S_DECRYPT: begin
            // r == 0 is the final cycle that moves the result to pt.
            if (r_rnd == 5'd0) begin
               w_fsm_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_fsm_nxt = S_IDLE;
         end
         default: begin
            w_fsm_nxt = S_IDLE;
         end
      endcase
   end

   // Output logic
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (r_fsm)
`ifdef PRESENT_KEYEXP_EN
         S_KEYEXP:  busy = 1'b1;
`endif
         S_DECRYPT: busy = 1'b1;
         S_DONE:    done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   assign pt = r_pt;

   // Datapath: cipher state, key register, round counter, result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= '0;
         r_key   <= '0;
         r_rnd   <= '0;
         r_pt    <= '0;
      end else begin
         unique case (r_fsm)
            S_IDLE: begin
               if (start) begin
`ifdef PRESENT_KEYEXP_EN
                  r_state <= ct;
                  r_key   <= key;
                  r_rnd   <= 5'd1;
`else
                  r_state <= ct ^ key[79:16];
                  r_key   <= key;
                  r_rnd   <= LAST;
`endif
               end
            end
`ifdef PRESENT_KEYEXP_EN
            S_KEYEXP: begin
               r_key <= key_fwd(r_key, r_rnd);
               // Counter parks at LAST: DECRYPT starts at round LAST.
               if (r_rnd != LAST) begin
                  r_rnd <= r_rnd + 5'd1;
               end
            end
`endif
            S_DECRYPT: begin
               if (r_rnd != 5'd0) begin
                  r_state <= w_rnd_out;
                  r_key   <= w_kr;
                  r_rnd   <= r_rnd - 5'd1;
               end else begin
                  r_pt <= r_state;
               end
            end
            default: begin
               r_pt <= r_pt;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present_dec.sv
// tb_present_dec: scoreboard bench for present_dec.
// Directed PRESENT-80 vectors plus re-start, reset and back-to-back cases.
`timescale 1ns/1ps
module tb_present_dec;

`ifdef PRESENT_KEYEXP_EN
   localparam int LAT    = 63;
   localparam int RST_AT = 40;
`else
   localparam int LAT    = 32;
   localparam int RST_AT = 20;
`endif

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [63:0] ct;
   logic [79:0] key;
   logic        busy;
   logic        done;
   logic [63:0] pt;

   present_dec #(.ROUNDS(31)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .ct    (ct),
      .key   (key),
      .busy  (busy),
      .done  (done),
      .pt    (pt)
   );

   typedef struct {
      logic [63:0] pt;
      int          at;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   logic prev_done = 1'b0;

   logic [63:0] v_ct [4];
   logic [79:0] v_key[4];
   logic [63:0] v_pt [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %h required %h (cycle %0d)",
                  nm, act, req, cyc);
      end
   endtask

   function automatic logic [3:0] m_sbox(input logic [3:0] x);
      logic [63:0] tbl;
      tbl = 64'hC56B90AD3EF84712;
      return tbl[4*(15 - int'(x)) +: 4];
   endfunction

   // Reference forward key schedule, user key -> K32.
   function automatic logic [79:0] m_k32(input logic [79:0] u);
      logic [79:0] k;
      k = u;
      for (int r = 1; r <= 31; r++) begin
         k          = {k[18:0], k[79:19]};
         k[79:76]   = m_sbox(k[79:76]);
         k[19:15]   = k[19:15] ^ 5'(r);
      end
      return k;
   endfunction

   function automatic logic [79:0] key_for(input logic [79:0] u);
`ifdef PRESENT_KEYEXP_EN
      return u;
`else
      return m_k32(u);
`endif
   endfunction

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (rst_n && done) begin
         chk("done_one_cycle", 64'(prev_done), 64'd0);
         chk("busy_low_in_done", 64'(busy), 64'd0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("pt", pt, e.pt);
            chk("latency", 64'(cyc), 64'(e.at));
         end
      end
      prev_done = rst_n && done;
   end

   task automatic issue(input int idx);
      ct    = v_ct[idx];
      key   = key_for(v_key[idx]);
      start = 1'b1;
      sb.push_back('{pt: v_pt[idx], at: cyc + 1 + LAT});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < LAT + 20; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      chk("done_within_bound", 64'(seen), 64'd1);
   endtask

   task automatic run_vec(input int idx);
      issue(idx);
      wait_done();
      @(negedge clk);
   endtask

   int nd;

   initial begin
      v_ct[0] = 64'h5579C1387B228445; v_key[0] = '0;
      v_pt[0] = 64'h0000000000000000;
      v_ct[1] = 64'hE72C46C0F5945049; v_key[1] = '1;
      v_pt[1] = 64'h0000000000000000;
      v_ct[2] = 64'hA112FFC72F68417B; v_key[2] = '0;
      v_pt[2] = 64'hFFFFFFFFFFFFFFFF;
      v_ct[3] = 64'h3333DCD3213210D2; v_key[3] = '1;
      v_pt[3] = 64'hFFFFFFFFFFFFFFFF;

      rst_n = 1'b0;
      start = 1'b0;
      ct    = '0;
      key   = '0;
      repeat (3) @(negedge clk);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_pt", pt, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 4; i++) run_vec(i);

      // Start re-pulsed at cycle 10 with other data: must be ignored.
      issue(2);
      repeat (9) @(negedge clk);
      chk("busy_mid_op", 64'(busy), 64'd1);
      ct    = v_ct[1];
      key   = key_for(v_key[1]);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);

      // Reset mid-operation.
      issue(0);
      repeat (RST_AT - 1) @(negedge clk);
      chk("busy_before_reset", 64'(busy), 64'd1);
      chk("pt_before_reset", pt, 64'hFFFFFFFFFFFFFFFF);
      rst_n = 1'b0;
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_pt", pt, 64'd0);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      nd = 0;
      repeat (LAT + 10) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("no_done_after_reset", 64'(nd), 64'd0);
      run_vec(1);

      // Back-to-back: start held from the done cycle; the DONE-cycle
      // edge must ignore it, the following IDLE edge must accept it.
      issue(3);
      wait_done();
      ct    = v_ct[0];
      key   = key_for(v_key[0]);
      start = 1'b1;
      sb.push_back('{pt: v_pt[0], at: cyc + 2 + LAT});
      repeat (2) @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (5) @(negedge clk);

      chk("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
